// File: rtl/status_flags_unit_pkg.sv
// Shared 6502 status-register definitions: flag bit positions, flag_op codes and ALU op codes.
package status_flags_unit_pkg;

  localparam int unsigned P_W       = 8;
  localparam int unsigned ALU_OP_W  = 3;
  localparam int unsigned FLAG_OP_W = 3;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_I = 2;
  localparam int unsigned FLAG_D = 3;
  localparam int unsigned FLAG_B = 4;
  localparam int unsigned FLAG_V = 6;
  localparam int unsigned FLAG_N = 7;

  localparam logic [ALU_OP_W-1:0] K_ALU_ORA = 3'd0;
  localparam logic [ALU_OP_W-1:0] K_ALU_AND = 3'd1;
  localparam logic [ALU_OP_W-1:0] K_ALU_EOR = 3'd2;
  localparam logic [ALU_OP_W-1:0] K_ALU_ADC = 3'd3;

  typedef enum logic [FLAG_OP_W-1:0] {
    FLG_NONE = 3'd0,
    FLG_CLC  = 3'd1,
    FLG_SEC  = 3'd2,
    FLG_CLI  = 3'd3,
    FLG_SEI  = 3'd4,
    FLG_CLV  = 3'd5,
    FLG_CLD  = 3'd6,
    FLG_SED  = 3'd7
  } flag_op_e;

  // Assemble the architectural P byte; bit 5 always reads as 1.
  function automatic logic [P_W-1:0] pack_p(input logic n, input logic v, input logic b,
                                            input logic d, input logic i, input logic z,
                                            input logic c);
    return {n, v, 1'b1, b, d, i, z, c};
  endfunction

endpackage

// File: rtl/status_flags_unit_irq_mask.sv
// Interrupt mask stage: I is sampled into the mask at opcode fetch, int_entry sets it at once.
module irq_mask_delay
  import status_flags_unit_pkg::*;
#(
  parameter bit   DELAY      = 1'b1,
  parameter logic RESET_MASK = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_i_q,
  input  logic i_i_d,
  input  logic i_instr_fetch,
  input  logic i_int_entry,
  output logic o_irq_mask
);

  logic r_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= RESET_MASK;
    end else if (i_int_entry) begin
      r_mask <= 1'b1;
    end else if (i_instr_fetch) begin
      r_mask <= i_i_d;
    end
  end

  // Without the delay the mask tracks the I register directly.
  assign o_irq_mask = DELAY ? r_mask : i_i_q;

endmodule

// File: rtl/status_flags_unit.sv
// Processor status (P) register: N/V/D/I/Z/C capture, flag instructions, pulls and
// interrupt entry, plus decimal-mode enables and interrupt mask for the datapath.
module status_flags_unit
  import status_flags_unit_pkg::*;
#(
  parameter logic [7:0] RESET_P        = 8'h34,
  parameter bit         IRQ_MASK_DELAY = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_carry,
  input  logic                 alu_overflow,
  input  logic                 alu_z,
  input  logic                 alu_n,
  input  logic [P_W-1:0]       db_in,
  input  logic [ALU_OP_W-1:0]  alu_op,
  input  logic                 alu_sub,
  input  logic                 load_nz,
  input  logic                 load_c,
  input  logic                 load_v,
  input  logic                 load_bit,
  input  logic                 load_p,
  input  logic [FLAG_OP_W-1:0] flag_op,
  input  logic                 int_entry,
  input  logic                 push_b,
  input  logic                 instr_fetch,
  output logic [P_W-1:0]       p_out,
  output logic                 c_out,
  output logic                 dec_add,
  output logic                 dec_sub,
  output logic                 irq_mask
);

  logic r_n, r_v, r_d, r_i, r_z, r_c;
  logic w_n, w_v, w_d, w_i, w_z, w_c;
  logic w_is_adc;

  // Next-state per flag; later assignments carry higher priority.
  always_comb begin
    w_n = r_n;
    w_v = r_v;
    w_d = r_d;
    w_i = r_i;
    w_z = r_z;
    w_c = r_c;

    if (load_nz) begin
      w_n = alu_n;
      w_z = alu_z;
    end
    if (load_c) w_c = alu_carry;
    if (load_v) w_v = alu_overflow;

    if (load_bit) begin
      w_n = db_in[FLAG_N];
      w_v = db_in[FLAG_V];
      w_z = alu_z;
    end

    case (flag_op)
      FLG_CLC: w_c = 1'b0;
      FLG_SEC: w_c = 1'b1;
      FLG_CLI: w_i = 1'b0;
      FLG_SEI: w_i = 1'b1;
      FLG_CLV: w_v = 1'b0;
      FLG_CLD: w_d = 1'b0;
      FLG_SED: w_d = 1'b1;
      default: ;
    endcase

    // Interrupt entry must not be undone by a coincident CLI.
    if (int_entry) w_i = 1'b1;

    if (load_p) begin
      w_n = db_in[FLAG_N];
      w_v = db_in[FLAG_V];
      w_d = db_in[FLAG_D];
      w_i = db_in[FLAG_I];
      w_z = db_in[FLAG_Z];
      w_c = db_in[FLAG_C];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n <= RESET_P[FLAG_N];
      r_v <= RESET_P[FLAG_V];
      r_d <= RESET_P[FLAG_D];
      r_i <= RESET_P[FLAG_I];
      r_z <= RESET_P[FLAG_Z];
      r_c <= RESET_P[FLAG_C];
    end else begin
      r_n <= w_n;
      r_v <= w_v;
      r_d <= w_d;
      r_i <= w_i;
      r_z <= w_z;
      r_c <= w_c;
    end
  end

  irq_mask_delay #(
    .DELAY      (IRQ_MASK_DELAY),
    .RESET_MASK (RESET_P[FLAG_I])
  ) u_irq_mask (
    .clk           (clk),
    .reset         (reset),
    .i_i_q         (r_i),
    .i_i_d         (w_i),
    .i_instr_fetch (instr_fetch),
    .i_int_entry   (int_entry),
    .o_irq_mask    (irq_mask)
  );

  assign w_is_adc = (alu_op == K_ALU_ADC);
  assign p_out    = pack_p(r_n, r_v, push_b, r_d, r_i, r_z, r_c);
  assign c_out    = r_c;
  assign dec_add  = r_d & w_is_adc & ~alu_sub;
  assign dec_sub  = r_d & w_is_adc & alu_sub;

endmodule

// File: tb/tb_status_flags_unit.sv
// Scoreboard bench for status_flags_unit: expected {p_out,c_out,dec_add,dec_sub,irq_mask}
// vectors are queued with each stimulus and compared after the clock edge.
module tb_status_flags_unit;
  import status_flags_unit_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_carry, alu_overflow, alu_z, alu_n;
  logic [7:0] db_in;
  logic [2:0] alu_op;
  logic       alu_sub, load_nz, load_c, load_v, load_bit, load_p;
  logic [2:0] flag_op;
  logic       int_entry, push_b, instr_fetch;
  logic [7:0] p_out;
  logic       c_out, dec_add, dec_sub, irq_mask;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  status_flags_unit dut (
    .clk          (clk),
    .reset        (reset),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .alu_z        (alu_z),
    .alu_n        (alu_n),
    .db_in        (db_in),
    .alu_op       (alu_op),
    .alu_sub      (alu_sub),
    .load_nz      (load_nz),
    .load_c       (load_c),
    .load_v       (load_v),
    .load_bit     (load_bit),
    .load_p       (load_p),
    .flag_op      (flag_op),
    .int_entry    (int_entry),
    .push_b       (push_b),
    .instr_fetch  (instr_fetch),
    .p_out        (p_out),
    .c_out        (c_out),
    .dec_add      (dec_add),
    .dec_sub      (dec_sub),
    .irq_mask     (irq_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] p, input logic c,
                            input logic da, input logic ds, input logic m);
    exp_q.push_back({p, c, da, ds, m});
    tag_q.push_back(tag);
  endtask

  task automatic compare_head();
    logic [11:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, 32'({p_out, c_out, dec_add, dec_sub, irq_mask}), 32'(e));
    end
  endtask

  task automatic clock_compare();
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic clear_strobes();
    load_nz = 0; load_c = 0; load_v = 0; load_bit = 0; load_p = 0;
    flag_op = FLG_NONE; int_entry = 0; instr_fetch = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    alu_carry = 0; alu_overflow = 0; alu_z = 0; alu_n = 0;
    db_in = 8'h00; alu_op = K_ALU_ORA; alu_sub = 0; push_b = 1;
    clear_strobes();

    repeat (2) @(negedge clk);
    expect_out("reset_p34", 8'h34, 0, 0, 0, 1);
    compare_head();
    reset = 1'b0;

    @(negedge clk); flag_op = FLG_SEC;
    expect_out("sec", 8'h35, 1, 0, 0, 1); clock_compare();

    @(negedge clk); flag_op = FLG_SED; alu_op = K_ALU_ADC; alu_sub = 0;
    expect_out("sed_dec_add", 8'h3D, 1, 1, 0, 1); clock_compare();

    @(negedge clk); flag_op = FLG_NONE; alu_sub = 1;
    expect_out("dec_sub", 8'h3D, 1, 0, 1, 1); clock_compare();

    // Asynchronous reset in the middle of the high phase, with an update pending.
    #2; flag_op = FLG_SEC; reset = 1'b1; #1;
    expect_out("async_rst_b1", 8'h34, 0, 0, 0, 1); compare_head();
    push_b = 0; #1;
    expect_out("async_rst_b0", 8'h24, 0, 0, 0, 1); compare_head();
    expect_out("rst_discard", 8'h24, 0, 0, 0, 1); clock_compare();

    @(negedge clk); reset = 1'b0; clear_strobes(); alu_op = K_ALU_ORA; alu_sub = 0;
    load_nz = 1; load_c = 1; load_v = 1;
    alu_n = 1; alu_z = 0; alu_carry = 1; alu_overflow = 1;
    expect_out("load_nzcv", 8'hE5, 1, 0, 0, 1); clock_compare();

    @(negedge clk); clear_strobes(); load_p = 1; db_in = 8'h00; flag_op = FLG_SEC;
    expect_out("plp_over_sec", 8'h20, 0, 0, 0, 1); clock_compare();

    @(negedge clk); clear_strobes(); load_p = 1; db_in = 8'h04; instr_fetch = 1;
    expect_out("plp_i_fetch", 8'h24, 0, 0, 0, 1); clock_compare();

    @(negedge clk); clear_strobes(); flag_op = FLG_CLI;
    expect_out("cli_mask_held", 8'h20, 0, 0, 0, 1); clock_compare();

    @(negedge clk); clear_strobes();
    expect_out("mask_hold_idle", 8'h20, 0, 0, 0, 1); clock_compare();

    @(negedge clk); clear_strobes(); instr_fetch = 1;
    expect_out("mask_at_fetch", 8'h20, 0, 0, 0, 0); clock_compare();

    @(negedge clk); clear_strobes(); flag_op = FLG_SEI; int_entry = 1;
    expect_out("sei_int_entry", 8'h24, 0, 0, 0, 1); clock_compare();

    @(negedge clk); clear_strobes(); flag_op = FLG_CLI; instr_fetch = 1;
    expect_out("cli_fetch", 8'h20, 0, 0, 0, 0); clock_compare();

    @(negedge clk); clear_strobes(); flag_op = FLG_CLI; int_entry = 1;
    expect_out("int_over_cli", 8'h24, 0, 0, 0, 1); clock_compare();

    @(negedge clk); clear_strobes(); push_b = 1;
    load_bit = 1; load_nz = 1; db_in = 8'hC0; alu_z = 1; alu_n = 0;
    expect_out("bit_c0", 8'hF6, 0, 0, 0, 1); clock_compare();

    @(negedge clk); clear_strobes(); flag_op = FLG_SEC; load_c = 1; alu_carry = 0;
    expect_out("sec_over_load_c", 8'hF7, 1, 0, 0, 1); clock_compare();

    @(negedge clk); clear_strobes(); flag_op = FLG_CLV; load_v = 1; alu_overflow = 1;
    expect_out("clv_over_load_v", 8'hB7, 1, 0, 0, 1); clock_compare();

    @(negedge clk); clear_strobes(); flag_op = FLG_CLC;
    expect_out("clc", 8'hB6, 0, 0, 0, 1); clock_compare();

    @(negedge clk); clear_strobes(); flag_op = FLG_SED; alu_op = K_ALU_ADC; alu_sub = 0;
    expect_out("sed_again", 8'hBE, 0, 1, 0, 1); clock_compare();

    @(negedge clk); clear_strobes(); flag_op = FLG_CLD;
    expect_out("cld_dec_off", 8'hB6, 0, 0, 0, 1); clock_compare();

    @(negedge clk); clear_strobes(); alu_op = K_ALU_EOR; load_nz = 1; alu_n = 0; alu_z = 0;
    expect_out("load_nz_clear", 8'h34, 0, 0, 0, 1); clock_compare();

    @(negedge clk); clear_strobes(); flag_op = FLG_SED; alu_sub = 1;
    expect_out("dec_non_adc", 8'h3C, 0, 0, 0, 1); clock_compare();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
